cpu_step_controller: RTL and testbench

- Sits directly downstream of the clock divider.
- Samples the divided slow clock (c0) and its locked flag in the fast board-clock domain.
- Produces a single-cycle clock-enable pulse (ce) that advances the single-cycle CPU.
- Supports free-run, pause and single-step from a board switch and a push-button, and counts retired CPU cycles for the debug display.

---
 rtl/cpu_step_controller_if.sv | 24 ++
 rtl/cpu_step_controller.sv | 150 +++++++++++++++
 tb/tb_cpu_step_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_step_controller_if.sv
// Control/status bundle between the board-side controls and the CPU step controller.
// The master drives the slow clock, lock flag and user inputs; the slave returns ce, mode and cycle count.
`timescale 1ns/1ps
interface cpu_step_controller_if #(
    parameter int CNT_W = 32
);
    logic             slowclk;
    logic             locked;
    logic             run_sw;
    logic             step_key_n;
    logic             ce;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output slowclk, locked, run_sw, step_key_n,
        input  ce, mode, cycle_count
    );

    modport slave (
        input  slowclk, locked, run_sw, step_key_n,
        output ce, mode, cycle_count
    );
endinterface

// File: rtl/cpu_step_controller.sv
// Turns the divided slow clock into a one-cycle CPU clock-enable with run/pause/single-step control.
// ce rises on the third inclk0 edge after slowclk is first sampled high; retired cycles are counted.
`timescale 1ns/1ps
module cpu_step_controller #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1000000,
    parameter int          CNT_W           = 32
) (
    input  logic                  inclk0,
    input  logic                  rst,
    cpu_step_controller_if.slave  step_if
);

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_RUN        = 2'd1,
        ST_PAUSE      = 2'd2,
        ST_STEP_ARMED = 2'd3
    } state_t;

    logic slow_s1_q, slow_s2_q, slow_s3_q;
    logic run_s1_q, run_s2_q;
    logic key_s1_q, key_s2_q;

    logic        key_acc_q, key_acc_d;
    logic [31:0] dbc_q, dbc_d;

    state_t           state_q, state_d;
    logic             seen_q, seen_d;
    logic             ce_q, ce_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic slow_rise;
    logic qual_rise;
    logic run_sync;
    logic key_differs;
    logic db_done;
    logic step_press;

    always_ff @(posedge inclk0 or posedge rst) begin
        if (rst) begin
            slow_s1_q <= 1'b0;
            slow_s2_q <= 1'b0;
            slow_s3_q <= 1'b0;
            run_s1_q  <= 1'b0;
            run_s2_q  <= 1'b0;
            key_s1_q  <= 1'b0;
            key_s2_q  <= 1'b0;
        end else begin
            slow_s1_q <= step_if.slowclk;
            slow_s2_q <= slow_s1_q;
            slow_s3_q <= slow_s2_q;
            run_s1_q  <= step_if.run_sw;
            run_s2_q  <= run_s1_q;
            key_s1_q  <= step_if.step_key_n;
            key_s2_q  <= key_s1_q;
        end
    end

    assign slow_rise = slow_s2_q & ~slow_s3_q;
    assign qual_rise = slow_rise & ~step_if.locked;
    assign run_sync  = run_s2_q;

    // The count restarts whenever the key agrees with the accepted level,
    // so only an unbroken run of differing samples can change it.
    assign key_differs = key_s2_q != key_acc_q;
    assign db_done     = key_differs && (dbc_q >= DEBOUNCE_CYCLES - 32'd1);
    assign step_press  = db_done & ~key_s2_q;

    always_comb begin
        dbc_d     = '0;
        key_acc_d = key_acc_q;
        if (key_differs) begin
            if (db_done) begin
                key_acc_d = key_s2_q;
            end else begin
                dbc_d = dbc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge inclk0 or posedge rst) begin
        if (rst) begin
            key_acc_q <= 1'b1;
            dbc_q     <= '0;
        end else begin
            key_acc_q <= key_acc_d;
            dbc_q     <= dbc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        ce_d    = 1'b0;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, ce_q};
        unique case (state_q)
            ST_RESET_WAIT: begin
                if (qual_rise) begin
                    if (seen_q) begin
                        state_d = run_sync ? ST_RUN : ST_PAUSE;
                    end else begin
                        seen_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!run_sync) begin
                    state_d = ST_PAUSE;
                end else if (qual_rise) begin
                    ce_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (run_sync) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    state_d = ST_STEP_ARMED;
                end
            end
            ST_STEP_ARMED: begin
                ce_d = qual_rise;
                if (run_sync) begin
                    state_d = ST_RUN;
                end else if (qual_rise) begin
                    state_d = ST_PAUSE;
                end
            end
            default: state_d = ST_RESET_WAIT;
        endcase
    end

    always_ff @(posedge inclk0 or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET_WAIT;
            seen_q  <= 1'b0;
            ce_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            ce_q    <= ce_d;
            cnt_q   <= cnt_d;
        end
    end

    assign step_if.ce          = ce_q;
    assign step_if.mode        = state_q;
    assign step_if.cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench: the stimulus thread queues each expected ce pulse; an independent monitor pops and checks it.
`timescale 1ns/1ps
module tb_cpu_step_controller;

    localparam int CNT_W = 4;

    typedef struct {
        int               cyc;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       mode;
    } exp_t;

    logic inclk0 = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   vectors = 0;
    int   fails   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    exp_t exp_q[$];
    exp_t mon_e;

    cpu_step_controller_if #(.CNT_W(CNT_W)) sif ();

    cpu_step_controller #(
        .DEBOUNCE_CYCLES(32'd4),
        .CNT_W          (CNT_W)
    ) dut (
        .inclk0 (inclk0),
        .rst    (rst),
        .step_if(sif)
    );

    always #10 inclk0 = ~inclk0;

    always @(posedge inclk0) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge inclk0) begin
        if (!rst && sif.ce) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_ce: got ce=1 at cycle %0d, required ce=0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ce_cycle", cyc, mon_e.cyc);
                chk("ce_count", int'(sif.cycle_count), int'(mon_e.cnt));
                chk("ce_mode", int'(sif.mode), int'(mon_e.mode));
            end
        end
    end

    // One slowclk period of 10 inclk0 cycles; the expected ce lands 3 edges after the rise is driven.
    task automatic rise(input bit exp_ce, input logic [1:0] exp_mode, input bit drop_run);
        @(negedge inclk0);
        sif.slowclk = 1'b1;
        if (drop_run) sif.run_sw = 1'b0;
        if (exp_ce) begin
            exp_q.push_back('{cyc + 3, exp_cnt, exp_mode});
            exp_cnt++;
        end
        repeat (5) @(negedge inclk0);
        sif.slowclk = 1'b0;
        repeat (4) @(negedge inclk0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200 us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sif.slowclk    = 1'b0;
        sif.locked     = 1'b0;
        sif.run_sw     = 1'b1;
        sif.step_key_n = 1'b1;
        repeat (3) @(negedge inclk0);
        rst = 1'b0;
        @(negedge inclk0);
        chk("reset_ce", int'(sif.ce), 0);
        chk("reset_mode", int'(sif.mode), 0);
        chk("reset_count", int'(sif.cycle_count), 0);

        // Startup: two qualifying rises are swallowed, then free-run
        rise(1'b0, 2'd0, 1'b0);
        chk("startup_mode_after_1", int'(sif.mode), 0);
        rise(1'b0, 2'd0, 1'b0);
        chk("startup_mode_run", int'(sif.mode), 1);
        for (int i = 0; i < 5; i++) rise(1'b1, 2'd1, 1'b0);
        chk("run_count_5", int'(sif.cycle_count), 5);

        // Locked rises are dropped, not deferred
        sif.locked = 1'b1;
        for (int i = 0; i < 3; i++) rise(1'b0, 2'd1, 1'b0);
        chk("locked_count_hold", int'(sif.cycle_count), 5);
        sif.locked = 1'b0;
        rise(1'b1, 2'd1, 1'b0);
        chk("unlocked_count", int'(sif.cycle_count), 6);

        // Pause then a bouncing press arms exactly one step
        @(negedge inclk0);
        sif.run_sw = 1'b0;
        repeat (4) @(negedge inclk0);
        chk("pause_mode", int'(sif.mode), 2);
        sif.step_key_n = 1'b0;
        @(negedge inclk0) sif.step_key_n = 1'b1;
        @(negedge inclk0) sif.step_key_n = 1'b0;
        repeat (10) @(negedge inclk0);
        chk("armed_mode", int'(sif.mode), 3);
        sif.step_key_n = 1'b1;
        repeat (10) @(negedge inclk0);
        chk("armed_after_release", int'(sif.mode), 3);
        rise(1'b1, 2'd2, 1'b0);
        chk("step_back_to_pause", int'(sif.mode), 2);
        chk("step_count", int'(sif.cycle_count), 7);

        sif.step_key_n = 1'b0;
        repeat (3) @(negedge inclk0);
        sif.step_key_n = 1'b1;
        repeat (10) @(negedge inclk0);
        chk("glitch_no_step", int'(sif.mode), 2);

        // Run beats a simultaneous press
        sif.run_sw     = 1'b1;
        sif.step_key_n = 1'b0;
        repeat (12) @(negedge inclk0);
        chk("run_over_step", int'(sif.mode), 1);
        sif.step_key_n = 1'b1;
        repeat (10) @(negedge inclk0);
        chk("run_after_press", int'(sif.mode), 1);

        // Pause arriving with the same slow_rise suppresses that ce
        rise(1'b0, 2'd1, 1'b1);
        chk("drop_run_mode", int'(sif.mode), 2);
        chk("drop_run_count", int'(sif.cycle_count), 7);

        // Asynchronous reset while ce is high
        sif.run_sw = 1'b1;
        repeat (4) @(negedge inclk0);
        chk("rerun_mode", int'(sif.mode), 1);
        @(negedge inclk0);
        sif.slowclk = 1'b1;
        exp_q.push_back('{cyc + 3, exp_cnt, 2'd1});
        repeat (3) @(negedge inclk0);
        chk("ce_before_rst", int'(sif.ce), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ce", int'(sif.ce), 0);
        chk("async_rst_mode", int'(sif.mode), 0);
        chk("async_rst_count", int'(sif.cycle_count), 0);
        exp_cnt = '0;
        @(negedge inclk0);
        sif.slowclk = 1'b0;
        repeat (3) @(negedge inclk0);
        rst = 1'b0;

        // Wrap of the 4-bit counter
        rise(1'b0, 2'd0, 1'b0);
        rise(1'b0, 2'd0, 1'b0);
        chk("restart_mode_run", int'(sif.mode), 1);
        for (int i = 1; i <= 17; i++) begin
            rise(1'b1, 2'd1, 1'b0);
            if (i == 15) chk("wrap_count_15", int'(sif.cycle_count), 15);
            if (i == 16) chk("wrap_count_0", int'(sif.cycle_count), 0);
            if (i == 17) chk("wrap_count_1", int'(sif.cycle_count), 1);
        end

        repeat (5) @(negedge inclk0);
        chk("pending_ce_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
